// File: rtl/jb_hs_pkg.sv
// jb_hs_pkg
//   Shared constants and types for the Jailbreak high-score RAM port arbiter.
//   - HS1_* / HS2_* : the two game RAM windows that back the high-score table.
//   - HS_BYTES      : total number of high-score bytes (index 0x00..0x52).
//   - hs_req_t      : one requester's command (index, write byte, direction).
//   - hs_rsp_tag_t  : per-access tag carried down the read-response pipeline.
package jb_hs_pkg;

   localparam logic [11:0] HS1_BASE = 12'h620;
   localparam logic [6:0]  HS1_LEN  = 7'h50;
   localparam logic [11:0] HS2_BASE = 12'h57E;
   localparam logic [6:0]  HS2_LEN  = 7'h03;
   localparam logic [6:0]  HS_BYTES = 7'd83;

   typedef struct packed {
      logic [6:0] index;
      logic [7:0] wdata;
      logic       is_write;
   } hs_req_t;

   typedef struct packed {
      logic valid;   // an accepted read occupies this slot
      logic id;      // requester that issued the read
      logic miss;    // index fell outside both windows
   } hs_rsp_tag_t;

endpackage

// File: rtl/jb_hs_window_map.sv
// jb_hs_window_map
//   Combinational mapping of a 7-bit high-score byte index onto the game RAM.
//   Ports:
//     index   in  7  : high-score byte index
//     address out 12 : RAM address (0 when the index misses)
//     hit     out 1  : index lies in one of the two windows
module jb_hs_window_map
   import jb_hs_pkg::*;
(
   input  logic [6:0]  index,
   output logic [11:0] address,
   output logic        hit
);

   logic [6:0] off2;

   always_comb begin
      address = '0;
      off2    = index - HS1_LEN;
      if (index < HS1_LEN) begin
         address = HS1_BASE + {5'd0, index};
      end else if (off2 < HS2_LEN) begin
         address = HS2_BASE + {5'd0, off2};
      end
      hit = (index < HS_BYTES);
   end

endmodule

// File: rtl/jb_hs_port_arbiter.sv
// jb_hs_port_arbiter
//   Shares the single high-score RAM port between requester 0 (bridge
//   save/load stream) and requester 1 (core-side scanner).
//
//   Handshake: req_ready is combinational and one-hot-or-zero; a request is
//   transferred in any cycle where req_valid[i] && req_ready[i]. Responses are
//   one-cycle strobes on rsp_valid[i] and cannot be back-pressured.
//
//   Ports:
//     jb_core_clk, reset_n (sync, active-low)
//     req_valid/req_ready/req_index/req_is_write/req_wdata : per-requester cmd
//     req0_lock        : hold off requester 1 while requester 0 owns the port
//     rsp_valid/rsp_data/rsp_miss : read responses, in request order
//     hs_address/hs_write_enable/hs_access_write/hs_data_in/hs_data_out : RAM
//     hs_dirty, dirty_clear : only when JB_HS_DIRTY_EN is defined
//   Parameter RD_LATENCY (1..2): RAM cycles from registered address to data.
module jb_hs_port_arbiter
   import jb_hs_pkg::*;
#(
   parameter int RD_LATENCY = 1
)
(
   input  logic            jb_core_clk,
   input  logic            reset_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [1:0][6:0] req_index,
   input  logic [1:0]      req_is_write,
   input  logic [1:0][7:0] req_wdata,
   input  logic            req0_lock,
   output logic [1:0]      rsp_valid,
   output logic [7:0]      rsp_data,
   output logic            rsp_miss,
   output logic [11:0]     hs_address,
   output logic            hs_write_enable,
   output logic            hs_access_write,
   output logic [7:0]      hs_data_in,
   input  logic [7:0]      hs_data_out
`ifdef JB_HS_DIRTY_EN
   ,
   output logic            hs_dirty,
   input  logic            dirty_clear
`endif
);

   logic        last_grant_q;
   logic        lock_active;
   logic        grant0;
   logic        grant1;
   logic        accept;
   hs_req_t     sel_req;
   logic [11:0] sel_addr;
   logic        sel_hit;
   hs_rsp_tag_t tag_q [0:RD_LATENCY];
   hs_rsp_tag_t rsp_tag;

   // Requester 0 wins a tie unless it was granted last; the lock only bites
   // once requester 0 has actually been granted. Grants are masked in reset.
   always_comb begin
      lock_active = req0_lock && !last_grant_q;
      grant0 = reset_n && req_valid[0] &&
               (!req_valid[1] || last_grant_q || lock_active);
      grant1 = reset_n && req_valid[1] && !grant0 && !lock_active;
      accept = grant0 || grant1;
   end

   assign req_ready = {grant1, grant0};

   always_comb begin
      sel_req.index    = req_index[grant1];
      sel_req.wdata    = req_wdata[grant1];
      sel_req.is_write = req_is_write[grant1];
   end

   jb_hs_window_map u_window_map (
      .index   (sel_req.index),
      .address (sel_addr),
      .hit     (sel_hit)
   );

   // RAM command stage plus the response tag shift register. The address is
   // only updated by in-window accesses so a miss leaves the RAM untouched.
   always_ff @(posedge jb_core_clk) begin
      if (!reset_n) begin
         last_grant_q    <= 1'b1;
         hs_address      <= '0;
         hs_write_enable <= 1'b0;
         hs_data_in      <= '0;
         for (int i = 0; i <= RD_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         hs_write_enable <= accept && sel_req.is_write && sel_hit;
         if (accept && sel_hit) begin
            hs_address <= sel_addr;
         end
         if (accept && sel_hit && sel_req.is_write) begin
            hs_data_in <= sel_req.wdata;
         end
         if (accept) begin
            last_grant_q <= grant1;
         end
         tag_q[0] <= '{valid: accept && !sel_req.is_write,
                       id:    grant1,
                       miss:  !sel_hit};
         for (int i = 1; i <= RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign hs_access_write = hs_write_enable;
   assign rsp_tag         = tag_q[RD_LATENCY];

   // The tag reaches the end of the shift register in the same cycle the RAM
   // presents the byte, so read data is passed straight through.
   always_comb begin
      rsp_valid = '0;
      rsp_miss  = 1'b0;
      rsp_data  = '0;
      if (rsp_tag.valid) begin
         rsp_valid[rsp_tag.id] = 1'b1;
         rsp_miss              = rsp_tag.miss;
         rsp_data              = rsp_tag.miss ? 8'h00 : hs_data_out;
      end
   end

`ifdef JB_HS_DIRTY_EN
   // Set has priority over clear so a concurrent scanner write is not lost.
   always_ff @(posedge jb_core_clk) begin
      if (!reset_n) begin
         hs_dirty <= 1'b0;
      end else if (grant1 && sel_req.is_write && sel_hit) begin
         hs_dirty <= 1'b1;
      end else if (dirty_clear) begin
         hs_dirty <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/jb_hs_port_arbiter.md
# jb_hs_port_arbiter

Shares the single high-score RAM port of the Jailbreak core between two byte-wide requesters in the `jb_core_clk` domain.
- Requester 0 is the bridge save/load stream arriving from the 74a→core CDC FIFO.
- Requester 1 is a core-side agent (snapshot/compare scanner).

Each request carries a 7-bit high-score byte index (0x00–0x52). The block maps the index onto the two game RAM windows, arbitrates round-robin with an optional lock for requester 0, and drives the RAM port through a fixed pipeline. Read data returns on a per-requester response strobe.

## Interface
- `RD_LATENCY`, default 1: RAM cycles from registered address to valid `hs_data_out`. Legal values are 1–2.
- `jb_core_clk` in 1: core clock.
- `reset_n` in 1: reset, synchronous, active-low. Clock is `jb_core_clk`.
- `req_valid[1:0]` in 2: per-requester request valid.
- `req_ready[1:0]` out 2: per-requester grant; a transfer happens when valid && ready.
- `req_index[2][6:0]` in 14: byte index per requester.
- `req_is_write[1:0]` in 2: 1 = write, 0 = read.
- `req_wdata[2][7:0]` in 16: write byte per requester.
- `req0_lock` in 1: while high after a requester-0 grant, requester 1 is never granted.
- `rsp_valid[1:0]` out 2: one-cycle read-response strobe per requester.
- `rsp_data` out 8: read byte, valid with `rsp_valid`.
- `rsp_miss` out 1: response was for an out-of-window index.
- `hs_address` out 12: RAM address.
- `hs_write_enable` out 1: RAM write strobe.
- `hs_access_write` out 1: same as `hs_write_enable`.
- `hs_data_in` out 8: RAM write data.
- `hs_data_out` in 8: RAM read data.
- `hs_dirty` out 1: present only with `JB_HS_DIRTY_EN`.
- `dirty_clear` in 1: present only with `JB_HS_DIRTY_EN`.

## Operation
- Index map:
  - 0x00–0x4F → 0x620 + index.
  - 0x50–0x52 → 0x57E + (index − 0x50).
  - 0x53–0x7F is a miss.
- Arbitration:
  - Combinational `req_ready`; at most one bit is set per cycle.
  - A lone valid requester is granted.
  - When both are valid, the requester not granted last wins. The `last_grant` register resets to 1, so requester 0 wins the first tie.
  - Lock: if `req0_lock` = 1 and `last_grant` = 0, `req_ready[1]` = 0 regardless of other inputs; requester 0 is granted whenever valid.
- Accepted write, in window: drive `hs_address`, `hs_data_in`, `hs_write_enable` = 1 for exactly one cycle. No response is produced.
- Accepted write, miss: dropped. No RAM write, no response.
- Accepted read, in window: `hs_address` is driven and `hs_write_enable` = 0. The response fires `RD_LATENCY` cycles later, with `rsp_data` = `hs_data_out` and `rsp_miss` = 0.
- Accepted read, miss: RAM is not addressed; `hs_address` holds its previous value. The response fires at the same latency as a hit, with `rsp_data` = 0x00 and `rsp_miss` = 1.
- Responses cannot be back-pressured; consumers must sample the strobe.
- The response pipeline carries requester id, read flag and miss flag, so responses stay in request order with one response per accepted read.

## Timing
- Request accepted in cycle N; RAM command registered and visible in N+1.
- Read response in cycle N+1+`RD_LATENCY` (N+2 at default).
- Throughput is one access per cycle, including back-to-back reads and writes to the same address.
- A read issued in the cycle after a write to the same address returns the new byte (RAM write-first is required at the RAM).
- Reset values:
  - `req_ready` = 0 during reset.
  - `hs_address` = 0.
  - `hs_write_enable` = 0, `hs_access_write` = 0.
  - `hs_data_in` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_miss` = 0.
  - `hs_dirty` = 0.
  - `last_grant` = 1.
- Reset mid-operation flushes the pipeline. Reads in flight produce no response; a write registered in the same cycle reset is sampled does not occur.

## Configuration
- Macro `JB_HS_DIRTY_EN`.
- Defined: `hs_dirty` sets on any in-window write accepted from requester 1. `dirty_clear` clears it. If set and clear coincide, set wins.
- Undefined: `hs_dirty` and `dirty_clear` ports and their logic are absent.

## Structure
- Package `jb_hs_pkg` holds:
  - `HS1_BASE` = 12'h620, `HS1_LEN` = 7'h50.
  - `HS2_BASE` = 12'h57E, `HS2_LEN` = 7'h03.
  - `HS_BYTES` = 7'd83.
  - `hs_req_t` struct: index, wdata, is_write.
- Sub-module `jb_hs_window_map` (combinational): 7-bit index in; 12-bit address and hit out.

## Test plan
- Reads of req0 index 0x00, 0x4F, 0x50, 0x52 → `hs_address` 0x620, 0x66F, 0x57E, 0x580 at N+1; `rsp_valid[0]` at N+2 with the RAM byte.
- req1 write index 0x10 data 0xA5, then req1 read index 0x10 the next cycle → write at 0x630, and the read returns 0xA5 with `rsp_miss` = 0.
- Both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1 with no idle cycle.
- `req0_lock` = 1 with both valid → only requester 0 is granted. After the lock drops, requester 1 is granted on the next tie.
- req0 read index 0x60 → no RAM address change; response data 0x00 with `rsp_miss` = 1 at N+2. A write to 0x60 produces no `hs_write_enable`.
- `JB_HS_DIRTY_EN` defined:
  - A requester-1 write to 0x05 sets `hs_dirty`.
  - `dirty_clear` concurrent with a new requester-1 write leaves `hs_dirty` = 1.
  - A requester-0 write does not set `hs_dirty`.
  - Reset asserted with a read in flight yields no `rsp_valid`.
